// File: rtl/conv_inst_sequencer_pkg.sv
// Shared definitions for the convolution instruction sequencer: instruction
// word bit positions, FSM state codes and the idle instruction word.
package conv_inst_sequencer_pkg;

    localparam int INST_W = 64;
    localparam int CNT_W  = 16;
    localparam int POS_W  = 8;

    localparam int B_REN_PMEM    = 35;
    localparam int B_SFU_PASS    = 34;
    localparam int B_ACC         = 33;
    localparam int B_CEN_PMEM    = 32;
    localparam int B_WEN_PMEM    = 31;
    localparam int B_A_PMEM_LSB  = 20;
    localparam int B_CEN_XMEM    = 19;
    localparam int B_WEN_XMEM    = 18;
    localparam int B_A_XMEM_LSB  = 7;
    localparam int B_OFIFO_RD    = 6;
    localparam int B_IFIFO_WR    = 5;
    localparam int B_IFIFO_RD    = 4;
    localparam int B_L0_RD       = 3;
    localparam int B_L0_WR       = 2;
    localparam int B_EXECUTE     = 1;
    localparam int B_LOAD        = 0;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_WL0    = 3'd1;
    localparam state_t S_WPE    = 3'd2;
    localparam state_t S_SETTLE = 3'd3;
    localparam state_t S_EXEC   = 3'd4;
    localparam state_t S_DRAIN  = 3'd5;
    localparam state_t S_DONE   = 3'd6;

    // Both memories disabled with write-enables inactive (high), all else low.
    localparam logic [INST_W-1:0] IDLE_INST = 64'h0000_0001_800C_0000;

endpackage

// File: rtl/onij_mapper.sv
// Maps the index of each OFIFO row read to its partial-sum address for the
// current kernel position, using position counters instead of dividers.
module onij_mapper
    import conv_inst_sequencer_pkg::*;
#(
    parameter int IN_W   = 6,
    parameter int K      = 3,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic              kij_clr_i,
    input  logic              kij_adv_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [POS_W-1:0]        NX_LAST  = POS_W'(IN_W - 1);
    localparam logic [3:0]              KX_LAST  = 4'(K - 1);
    localparam logic signed [POS_W+1:0] OUT_W_S  = (POS_W + 2)'(IN_W - K + 1);
    localparam logic [19:0]             OUT_W_U  = 20'(IN_W - K + 1);

    logic [POS_W-1:0]        nx_q, nx_d, ny_q, ny_d;
    logic [3:0]              kx_q, kx_d, ky_q, ky_d;
    logic signed [POS_W+1:0] ox_s, oy_s;
    logic [19:0]             addr_full_s;
    logic                    valid_s;

    // Input column/row of the next OFIFO read.
    always_comb begin
        nx_d = nx_q;
        ny_d = ny_q;
        if (clr_i) begin
            nx_d = '0;
            ny_d = '0;
        end else if (adv_i) begin
            if (nx_q == NX_LAST) begin
                nx_d = '0;
                ny_d = ny_q + POS_W'(1);
            end else begin
                nx_d = nx_q + POS_W'(1);
            end
        end else begin
            nx_d = nx_q;
        end
    end

    // Kernel column/row of the current kernel position.
    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        if (kij_clr_i) begin
            kx_d = '0;
            ky_d = '0;
        end else if (kij_adv_i) begin
            if (kx_q == KX_LAST) begin
                kx_d = '0;
                ky_d = ky_q + 4'd1;
            end else begin
                kx_d = kx_q + 4'd1;
            end
        end else begin
            kx_d = kx_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            nx_q <= '0;
            ny_q <= '0;
            kx_q <= '0;
            ky_q <= '0;
        end else begin
            nx_q <= nx_d;
            ny_q <= ny_d;
            kx_q <= kx_d;
            ky_q <= ky_d;
        end
    end

    // Output pixel coordinates, range check and linear address.
    always_comb begin
        ox_s        = $signed({2'b00, nx_q}) - $signed({{(POS_W - 2){1'b0}}, kx_q});
        oy_s        = $signed({2'b00, ny_q}) - $signed({{(POS_W - 2){1'b0}}, ky_q});
        valid_s     = !ox_s[POS_W+1] && (ox_s < OUT_W_S) &&
                      !oy_s[POS_W+1] && (oy_s < OUT_W_S);
        addr_full_s = {{(19 - POS_W){1'b0}}, ox_s[POS_W:0]} +
                      ({{(19 - POS_W){1'b0}}, oy_s[POS_W:0]} * OUT_W_U);
        if (valid_s) begin
            addr_o = addr_full_s[ADDR_W-1:0];
        end else begin
            addr_o = '0;
        end
        valid_o = valid_s;
    end

endmodule

// File: rtl/conv_inst_sequencer.sv
// Sequences one full convolution pass: per kernel position it loads weights
// into L0 and the PE array, streams activations, and accumulates OFIFO rows.
module conv_inst_sequencer
    import conv_inst_sequencer_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int IN_W   = 6,
    parameter int K      = 3,
    parameter int ADDR_W = 11,
    parameter int WBASE  = 1024,
    parameter int GAP    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        kij
);

    localparam int NIJ = IN_W * IN_W;
    localparam int KIJ = K * K;

    localparam logic [CNT_W-1:0]  WL0_LAST    = CNT_W'(COL);
    localparam logic [CNT_W-1:0]  WPE_LAST    = CNT_W'(COL + ROW);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0]  NIJ_C       = CNT_W'(NIJ);
    localparam logic [3:0]        KIJ_LAST    = 4'(KIJ - 1);
    localparam logic [ADDR_W-1:0] WBASE_A     = ADDR_W'(WBASE);
    localparam logic [ADDR_W-1:0] COL_A       = ADDR_W'(COL);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [3:0]         kij_q, kij_d;

    logic               rd_s;
    logic               rd_done_s;
    logic               rd_clr_s;
    logic               kij_clr_s;
    logic               kij_adv_s;
    logic               map_valid_s;
    logic [ADDR_W-1:0]  map_addr_s;
    logic [ADDR_W-1:0]  wl_addr_s;
    logic [INST_W-1:0]  inst_s;

    // A row is taken whenever one is offered and the position still expects rows.
    always_comb begin
        rd_s      = ((state_q == S_EXEC) || (state_q == S_DRAIN)) &&
                    ofifo_valid && (rd_cnt_q < NIJ_C);
        rd_done_s = ((rd_cnt_q + {{(CNT_W - 1){1'b0}}, rd_s}) == NIJ_C);
    end

    onij_mapper #(
        .IN_W   (IN_W),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) u_mapper (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (rd_clr_s),
        .adv_i     (rd_s),
        .kij_clr_i (kij_clr_s),
        .kij_adv_i (kij_adv_s),
        .valid_o   (map_valid_s),
        .addr_o    (map_addr_s)
    );

    // Phase sequencing and per-position bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_cnt_d  = rd_cnt_q;
        kij_d     = kij_q;
        rd_clr_s  = 1'b0;
        kij_clr_s = 1'b0;
        kij_adv_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WL0;
                    cnt_d     = '0;
                    rd_cnt_d  = '0;
                    kij_d     = 4'd0;
                    rd_clr_s  = 1'b1;
                    kij_clr_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WL0: begin
                if (cnt_q == WL0_LAST) begin
                    state_d = S_WPE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WPE: begin
                if (cnt_q == WPE_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_EXEC, S_DRAIN: begin
                rd_cnt_d = rd_cnt_q + {{(CNT_W - 1){1'b0}}, rd_s};
                if ((state_q == S_DRAIN) || (cnt_q == NIJ_C)) begin
                    cnt_d = '0;
                    // Leave the position only once the last of its rows is taken.
                    if (rd_done_s) begin
                        rd_cnt_d = '0;
                        rd_clr_s = 1'b1;
                        if (kij_q == KIJ_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d   = S_WL0;
                            kij_d     = kij_q + 4'd1;
                            kij_adv_s = 1'b1;
                        end
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_cnt_q <= '0;
            kij_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_cnt_q <= rd_cnt_d;
            kij_q    <= kij_d;
        end
    end

    // Instruction word for the current phase cycle.
    always_comb begin
        inst_s    = IDLE_INST;
        wl_addr_s = WBASE_A + (ADDR_W'(kij_q) * COL_A) + cnt_q[ADDR_W-1:0];
        case (state_q)
            S_WL0: begin
                if (cnt_q < WL0_LAST) begin
                    inst_s[B_CEN_XMEM]                   = 1'b0;
                    inst_s[B_A_XMEM_LSB +: ADDR_W]       = wl_addr_s;
                end else begin
                    inst_s[B_CEN_XMEM]                   = 1'b1;
                end
                inst_s[B_L0_WR] = (cnt_q != 16'd0);
            end
            S_WPE: begin
                inst_s[B_L0_RD] = 1'b1;
                inst_s[B_LOAD]  = (cnt_q != 16'd0);
            end
            S_EXEC: begin
                if (cnt_q < NIJ_C) begin
                    inst_s[B_CEN_XMEM]                   = 1'b0;
                    inst_s[B_A_XMEM_LSB +: ADDR_W]       = cnt_q[ADDR_W-1:0];
                end else begin
                    inst_s[B_CEN_XMEM]                   = 1'b1;
                end
                inst_s[B_L0_WR]   = (cnt_q != 16'd0);
                inst_s[B_L0_RD]   = (cnt_q != 16'd0);
                inst_s[B_EXECUTE] = (cnt_q != 16'd0);
            end
            default: begin
                inst_s = IDLE_INST;
            end
        endcase
        if (rd_s) begin
            inst_s[B_OFIFO_RD] = 1'b1;
            inst_s[B_SFU_PASS] = (kij_q == 4'd0);
            inst_s[B_ACC]      = (kij_q != 4'd0);
            // Rows that fall outside the output map are read and dropped.
            if (map_valid_s) begin
                inst_s[B_CEN_PMEM]             = 1'b0;
                inst_s[B_WEN_PMEM]             = 1'b0;
                inst_s[B_A_PMEM_LSB +: ADDR_W] = map_addr_s;
            end else begin
                inst_s[B_CEN_PMEM]             = 1'b1;
            end
        end else begin
            inst_s[B_OFIFO_RD] = 1'b0;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        inst = inst_s;
        busy = (state_q != S_IDLE) && (state_q != S_DONE);
        done = (state_q == S_DONE);
        kij  = kij_q;
    end

endmodule

// File: tb/tb_conv_inst_sequencer.sv
// Directed bench: a procedural walk of each convolution pass predicts every
// instruction word, and cycle-level comparisons check the DUT against it.
module tb_conv_inst_sequencer;

    localparam logic [63:0] IDLE_W = 64'h0000_0001_800C_0000;

    logic        clk = 1'b0;
    logic        reset, start, vld;
    int          sel;
    logic        start0, start1, vld0, vld1;
    logic [63:0] inst0, inst1;
    logic        busy0, busy1, done0, done1;
    logic [3:0]  kij0, kij1;

    int checks = 0;
    int errors = 0;
    int n_rd, n_pw, n_wl, n_done;

    always #5 clk = ~clk;

    assign start0 = (sel == 0) ? start : 1'b0;
    assign vld0   = (sel == 0) ? vld   : 1'b0;
    assign start1 = (sel == 1) ? start : 1'b0;
    assign vld1   = (sel == 1) ? vld   : 1'b0;

    conv_inst_sequencer dut0 (
        .clk(clk), .reset(reset), .start(start0), .ofifo_valid(vld0),
        .inst(inst0), .busy(busy0), .done(done0), .kij(kij0)
    );

    conv_inst_sequencer #(.ROW(4), .COL(4), .IN_W(5), .K(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ofifo_valid(vld1),
        .inst(inst1), .busy(busy1), .done(done1), .kij(kij1)
    );

    task automatic report(input string name, input string got, input string want);
        errors++;
        if (errors <= 40) $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) report(name, $sformatf("%0d", got), $sformatf("%0d", want));
    endtask

    // Compare one cycle at the falling edge, then step to just after the next rising edge.
    task automatic expect_cycle(input logic [63:0] ew, input logic eb, input logic ed,
                                input int ek, input string tag);
        logic [63:0] ai;
        logic        ab, ad;
        logic [3:0]  ak;
        int          colv;
        @(negedge clk);
        ai   = (sel == 0) ? inst0 : inst1;
        ab   = (sel == 0) ? busy0 : busy1;
        ad   = (sel == 0) ? done0 : done1;
        ak   = (sel == 0) ? kij0  : kij1;
        colv = (sel == 0) ? 8 : 4;
        checks++;
        if (ai !== ew) report({tag, " inst"}, $sformatf("%h", ai), $sformatf("%h", ew));
        checks++;
        if (ab !== eb) report({tag, " busy"}, $sformatf("%b", ab), $sformatf("%b", eb));
        checks++;
        if (ad !== ed) report({tag, " done"}, $sformatf("%b", ad), $sformatf("%b", ed));
        if (ek >= 0) begin
            checks++;
            if (ak !== 4'(ek)) report({tag, " kij"}, $sformatf("%0d", ak), $sformatf("%0d", ek));
        end
        if (ai[6] === 1'b1) n_rd++;
        if (ai[32] === 1'b0 && ai[31] === 1'b0) n_pw++;
        if (ai[19] === 1'b0 && int'(ai[17:7]) == 1024 + int'(ak) * colv) n_wl++;
        if (ad === 1'b1) n_done++;
        @(posedge clk);
        #1;
    endtask

    // Walk one pass from the IDLE cycle that samples start to the DONE cycle.
    task automatic run_pass(input int s, input bit hold, input int abort_kij, input int stall_kij);
        int row, col, inw, k, nij, nk, outw, rd, t, nx, ny, ox, oy;
        bit v, r, aborted;
        logic [63:0] w;
        row  = (s == 0) ? 8 : 4;
        col  = (s == 0) ? 8 : 4;
        inw  = (s == 0) ? 6 : 5;
        k    = (s == 0) ? 3 : 2;
        nij  = inw * inw;
        nk   = k * k;
        outw = inw - k + 1;
        aborted = 1'b0;
        start = 1'b1;
        vld   = 1'b0;
        expect_cycle(IDLE_W, 1'b0, 1'b0, -1, "idle_start");
        if (!hold) start = 1'b0;
        for (int kk = 0; kk < nk && !aborted; kk++) begin
            for (int c = 0; c <= col; c++) begin
                w = IDLE_W;
                if (c < col) begin
                    w[19]   = 1'b0;
                    w[17:7] = 11'(1024 + kk * col + c);
                end
                if (c >= 1) w[2] = 1'b1;
                if (s == 0 && kk == 2 && c == 0) begin
                    check_int("k2_wl0_c0_axmem", int'(w[17:7]), 1040);
                    check_int("k2_wl0_c0_cen", int'(w[19]), 0);
                    check_int("k2_wl0_c0_l0wr", int'(w[2]), 0);
                end
                if (s == 0 && kk == 2 && c == 8) begin
                    check_int("k2_wl0_c8_l0wr", int'(w[2]), 1);
                    check_int("k2_wl0_c8_cen", int'(w[19]), 1);
                end
                expect_cycle(w, 1'b1, 1'b0, kk, "wl0");
            end
            for (int c = 0; c <= col + row; c++) begin
                w    = IDLE_W;
                w[3] = 1'b1;
                if (c >= 1) w[0] = 1'b1;
                expect_cycle(w, 1'b1, 1'b0, kk, "wpe");
            end
            for (int c = 0; c < 10; c++) expect_cycle(IDLE_W, 1'b1, 1'b0, kk, "settle");
            rd = 0;
            t  = 0;
            forever begin
                v   = (t >= 9) && !(kk == stall_kij && t > nij && t <= nij + 20);
                vld = v;
                if (kk == abort_kij && t == 3) reset = 1'b0;
                w = IDLE_W;
                if (t < nij) begin
                    w[19]   = 1'b0;
                    w[17:7] = 11'(t);
                end
                if (t >= 1 && t <= nij) begin
                    w[3] = 1'b1;
                    w[2] = 1'b1;
                    w[1] = 1'b1;
                end
                r = v && (rd < nij);
                if (r) begin
                    w[6]  = 1'b1;
                    w[34] = (kk == 0);
                    w[33] = (kk != 0);
                    nx = rd % inw;
                    ny = rd / inw;
                    ox = nx - (kk % k);
                    oy = ny - (kk / k);
                    if (ox >= 0 && ox < outw && oy >= 0 && oy < outw) begin
                        w[32]    = 1'b0;
                        w[31]    = 1'b0;
                        w[30:20] = 11'(ox + oy * outw);
                    end
                    if (s == 0 && kk == 4 && rd == 6) check_int("k4_n6_cenp", int'(w[32]), 1);
                    if (s == 0 && kk == 4 && rd == 7) begin
                        check_int("k4_n7_cenp", int'(w[32]), 0);
                        check_int("k4_n7_apmem", int'(w[30:20]), 0);
                    end
                    if (s == 0 && kk == 4 && rd == 14) begin
                        check_int("k4_n14_apmem", int'(w[30:20]), 5);
                        check_int("k4_n14_acc", int'(w[33]), 1);
                    end
                end
                expect_cycle(w, 1'b1, 1'b0, kk, (t <= nij) ? "exec" : "drain");
                if (reset == 1'b0) begin
                    aborted = 1'b1;
                    break;
                end
                if (r) rd++;
                if (t >= nij && rd == nij) break;
                t++;
                if (t > 3000) begin
                    check_int("drain_timeout", t, 0);
                    break;
                end
            end
        end
        vld = 1'b0;
        if (!aborted) expect_cycle(IDLE_W, 1'b0, 1'b1, -1, "done");
    endtask

    task automatic clear_counts();
        n_rd = 0; n_pw = 0; n_wl = 0; n_done = 0;
    endtask

    task automatic check_counts(input string tag, input int rdw, input int pww, input int wlw);
        check_int({tag, " ofifo_rd pulses"}, n_rd, rdw);
        check_int({tag, " pmem writes"}, n_pw, pww);
        check_int({tag, " wl0 sequences"}, n_wl, wlw);
        check_int({tag, " done pulses"}, n_done, 1);
    endtask

    initial begin
        sel   = 0;
        reset = 1'b0;
        start = 1'b0;
        vld   = 1'b0;
        clear_counts();
        @(posedge clk);
        #1;
        expect_cycle(IDLE_W, 1'b0, 1'b0, 0, "reset");
        expect_cycle(IDLE_W, 1'b0, 1'b0, 0, "reset");
        reset = 1'b1;
        expect_cycle(IDLE_W, 1'b0, 1'b0, 0, "post_reset");

        // Pass with start held high throughout: it is ignored, then restarts.
        clear_counts();
        run_pass(0, 1'b1, -1, -1);
        check_counts("default", 324, 144, 9);

        // Back-to-back pass aborted by reset during EXEC of kernel position 5.
        run_pass(0, 1'b0, 5, -1);
        start = 1'b0;
        vld   = 1'b0;
        expect_cycle(IDLE_W, 1'b0, 1'b0, 0, "abort_reset");
        reset = 1'b1;
        expect_cycle(IDLE_W, 1'b0, 1'b0, 0, "abort_idle");

        // Fresh pass after reset with a 20-cycle OFIFO stall at kernel position 1.
        clear_counts();
        run_pass(0, 1'b0, -1, 1);
        check_counts("stall", 324, 144, 9);
        expect_cycle(IDLE_W, 1'b0, 1'b0, -1, "idle_after");

        // Small configuration: 5x5 input, 2x2 kernel, 4x4 array.
        sel = 1;
        clear_counts();
        expect_cycle(IDLE_W, 1'b0, 1'b0, 0, "small_idle");
        run_pass(1, 1'b0, -1, -1);
        check_counts("small", 100, 64, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
